// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM encoding and flag positions for the ALU command sequencer.
// The optional illegal-opcode path (ALU_SEQ_ILLEGAL_OP_EN) uses is_illegal().
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_DIV = 4'b0101;
  localparam logic [3:0] OP_SHR = 4'b0110;
  localparam logic [3:0] OP_SHL = 4'b0111;
  localparam logic [3:0] OP_CMP = 4'b1000;
  localparam logic [3:0] OP_SLT = 4'b1001;
  localparam logic [3:0] OP_REM = 4'b1010;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return op > OP_REM;
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Initiator for an external 32-bit ALU: registers operands, waits a per-opcode
// settle time, captures result/flags and returns them. Optional: ALU_SEQ_ILLEGAL_OP_EN.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int MULDIV_WAIT = 2,
  parameter int BASIC_WAIT  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic        cmd_use_acc,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_overflow,
  input  logic        alu_carry,
  input  logic        alu_zero,
  input  logic        alu_negative,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic        rsp_err,
  output logic        busy
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // cmd_ready depends on state only; rsp_valid, once high, holds until rsp_ready.
  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       acc;

  assign cmd_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);

`ifdef ALU_SEQ_ILLEGAL_OP_EN
  logic rsp_err_q;
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      acc        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
`ifdef ALU_SEQ_ILLEGAL_OP_EN
      rsp_err_q  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
`ifdef ALU_SEQ_ILLEGAL_OP_EN
            // Illegal opcodes never reach the ALU; answer immediately.
            if (is_illegal(cmd_op)) begin
              rsp_result <= '0;
              rsp_flags  <= '0;
              rsp_err_q  <= 1'b1;
              state      <= ST_RESP;
            end else
`endif
            begin
              alu_a    <= cmd_use_acc ? acc : cmd_a;
              alu_b    <= cmd_b;
              alu_ctrl <= cmd_op;
              cnt      <= is_multicycle(cmd_op) ? CNT_W'(MULDIV_WAIT) : CNT_W'(BASIC_WAIT);
              state    <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp_result        <= alu_result;
            rsp_flags[FLAG_N] <= alu_negative;
            rsp_flags[FLAG_Z] <= alu_zero;
            rsp_flags[FLAG_C] <= alu_carry;
            rsp_flags[FLAG_V] <= alu_overflow;
            acc               <= alu_result;
`ifdef ALU_SEQ_ILLEGAL_OP_EN
            rsp_err_q         <= 1'b0;
`endif
            state             <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  a_rsp_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_result) && $stable(rsp_flags)));

  a_alu_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (state == ST_EXEC) |=> ($stable(alu_a) && $stable(alu_b) && $stable(alu_ctrl)));

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: behavioural ALU, directed vector table, hand
// sequences for backpressure/reset/illegal opcodes, and randomized commands.
module tb_alu_cmd_sequencer;

  localparam int MDW = 2;
  localparam int BW  = 0;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready, cmd_use_acc;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_a, cmd_b;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_ctrl;
  logic        alu_overflow, alu_carry, alu_zero, alu_negative;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;

  int checks = 0;
  int errors = 0;

  // Bench-side model state: accumulator and last values placed on the ALU pins.
  logic [31:0] m_acc, m_a, m_b;
  logic [3:0]  m_ctrl;

  alu_cmd_sequencer #(.MULDIV_WAIT(MDW), .BASIC_WAIT(BW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_carry(alu_carry),
    .alu_zero(alu_zero), .alu_negative(alu_negative),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural ALU ----------------
  // Returns {N,Z,C,V,result}. C on SUB means "no borrow" (a >= b unsigned).
  function automatic logic [35:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic        c, v;
    c = 1'b0;
    v = 1'b0;
    r = '0;
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
                  v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd1: begin r = a - b; c = (a >= b); v = (a[31] != b[31]) && (r[31] != a[31]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a * b;
      4'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd6: r = a >> b[4:0];
      4'd7: r = a << b[4:0];
      4'd8: r = (a == b) ? 32'd1 : 32'd0;
      4'd9: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd10: r = (b == 0) ? a : a % b;
      default: r = '0;
    endcase
    return {r[31], (r == 0), c, v, r};
  endfunction

  always_comb begin
    logic [35:0] o;
    o = alu_ref(alu_ctrl, alu_a, alu_b);
    alu_negative = o[35];
    alu_zero     = o[34];
    alu_carry    = o[33];
    alu_overflow = o[32];
    alu_result   = o[31:0];
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one command, follow it to the response, optionally hold off rsp_ready
  // (with a spurious cmd_valid) and complete the handshake.
  task automatic run_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic use_acc,
                         input logic [31:0] e_a, input logic [31:0] e_b, input logic [3:0] e_ctrl,
                         input logic [31:0] e_res, input logic [3:0] e_fl, input logic e_err,
                         input int e_lat, input int hold, input logic spur);
    int lat;
    logic [31:0] held;
    @(negedge clk);
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = use_acc;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_a = $urandom; cmd_b = $urandom;
    lat = 0;
    forever begin
      @(negedge clk);
      if (rsp_valid || lat > 20) break;
      chk("exec_alu_a", alu_a, e_a);
      chk("exec_alu_b", alu_b, e_b);
      chk("exec_alu_ctrl", 32'(alu_ctrl), 32'(e_ctrl));
      chk("exec_busy", 32'(busy), 32'd1);
      chk("exec_cmd_ready", 32'(cmd_ready), 32'd0);
      @(posedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(e_lat));
    chk("rsp_result", rsp_result, e_res);
    chk("rsp_flags", 32'(rsp_flags), 32'(e_fl));
    chk("rsp_err", 32'(rsp_err), 32'(e_err));
    chk("rsp_alu_ctrl", 32'(alu_ctrl), 32'(e_ctrl));
    held = rsp_result;
    for (int i = 0; i < hold; i++) begin
      if (spur) begin
        cmd_valid = 1'b1; cmd_op = 4'd1; cmd_a = $urandom; cmd_use_acc = 1'b0;
      end
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_result", rsp_result, held);
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_alu_ctrl", 32'(alu_ctrl), 32'(e_ctrl));
  endtask

  // Model-driven command: expectations come from alu_ref and the bench accumulator.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic use_acc, input int hold);
    logic [31:0] opa;
    logic [35:0] o;
    int          lat;
    opa = use_acc ? m_acc : a;
`ifdef ALU_SEQ_ILLEGAL_OP_EN
    if (op > 4'd10) begin
      run_cmd(op, a, b, use_acc, m_a, m_b, m_ctrl, 32'd0, 4'd0, 1'b1, 0, hold, 1'b0);
    end else
`endif
    begin
      o   = alu_ref(op, opa, b);
      lat = (op == 4'd4 || op == 4'd5 || op == 4'd10) ? 1 + MDW : 1 + BW;
      run_cmd(op, a, b, use_acc, opa, b, op, o[31:0], o[35:32], 1'b0, lat, hold, 1'b0);
      m_acc = o[31:0]; m_a = opa; m_b = b; m_ctrl = op;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        use_acc;
    logic [31:0] e_a;
    logic [31:0] e_res;
    logic [3:0]  e_fl;
    int          e_lat;
    int          hold;
  } vec_t;

  vec_t vec[11];

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    cmd_use_acc = 1'b0; rsp_ready = 1'b0;
    m_acc = '0; m_a = '0; m_b = '0; m_ctrl = '0;

    //            op     a             b             acc   e_a           e_res         NZCV     lat hold
    vec[0]  = '{4'd0,  32'hFFFF_FFFF, 32'h1,        1'b0, 32'hFFFF_FFFF, 32'h0,        4'b0110, 1, 0};
    vec[1]  = '{4'd1,  32'h8000_0000, 32'h1,        1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 4'b0011, 1, 0};
    vec[2]  = '{4'd0,  32'hDEAD_BEEF, 32'h1,        1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 4'b1001, 1, 0};
    vec[3]  = '{4'd5,  32'd100,       32'd7,        1'b0, 32'd100,       32'd14,        4'b0000, 3, 5};
    vec[4]  = '{4'd10, 32'd100,       32'd7,        1'b0, 32'd100,       32'd2,         4'b0000, 3, 0};
    vec[5]  = '{4'd4,  32'h1234_5678, 32'h4000_0000, 1'b1, 32'd2,        32'h8000_0000, 4'b1000, 3, 1};
    vec[6]  = '{4'd2,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 32'hF0F0_F0F0, 32'h00F0_00F0, 4'b0000, 1, 0};
    vec[7]  = '{4'd7,  32'h1,         32'd31,       1'b0, 32'h1,         32'h8000_0000, 4'b1000, 1, 0};
    vec[8]  = '{4'd9,  32'hFFFF_FFFF, 32'h1,        1'b0, 32'hFFFF_FFFF, 32'h1,         4'b0000, 1, 2};
    vec[9]  = '{4'd3,  32'h0,         32'h0,        1'b0, 32'h0,         32'h0,         4'b0100, 1, 0};
    vec[10] = '{4'd6,  32'h8000_0000, 32'd4,        1'b0, 32'h8000_0000, 32'h0800_0000, 4'b0000, 1, 0};

    // Reset values (asynchronous, checked away from any clock edge).
    #12;
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_alu_b", alu_b, 32'h0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_result", rsp_result, 32'h0);
    chk("rst_rsp_flags", 32'(rsp_flags), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 11; i++) begin
      run_cmd(vec[i].op, vec[i].a, vec[i].b, vec[i].use_acc, vec[i].e_a, vec[i].b, vec[i].op,
              vec[i].e_res, vec[i].e_fl, 1'b0, vec[i].e_lat, vec[i].hold, (vec[i].hold > 0));
      m_acc = vec[i].e_res; m_a = vec[i].e_a; m_b = vec[i].b; m_ctrl = vec[i].op;
    end

    // Reset in the middle of a MUL: everything clears, no response follows.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'd4; cmd_a = 32'd3; cmd_b = 32'd5; cmd_use_acc = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("mul_busy_before_rst", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_alu_a", alu_a, 32'h0);
    chk("midrst_alu_b", alu_b, 32'h0);
    chk("midrst_alu_ctrl", 32'(alu_ctrl), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("midrst_rsp_result", rsp_result, 32'h0);
    chk("midrst_rsp_flags", 32'(rsp_flags), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("postrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    m_acc = '0; m_a = '0; m_b = '0; m_ctrl = '0;
    // Accumulator must be zero: ADD acc + 0 puts 0 on alu_a and returns Z.
    run_cmd(4'd0, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 32'h0, 4'd0, 32'h0, 4'b0100, 1'b0, 1, 0, 1'b0);

    // Illegal opcode after a known legal command.
    issue(4'd3, 32'h0000_00A5, 32'h0000_5A00, 1'b0, 0);
`ifdef ALU_SEQ_ILLEGAL_OP_EN
    run_cmd(4'hC, 32'd9, 32'd9, 1'b0, 32'h0000_00A5, 32'h0000_5A00, 4'd3,
            32'h0, 4'b0000, 1'b1, 0, 1, 1'b0);
    // Accumulator still holds the OR result.
    issue(4'd0, 32'd0, 32'd0, 1'b1, 0);
`else
    run_cmd(4'hC, 32'd9, 32'd9, 1'b0, 32'd9, 32'd9, 4'hC,
            32'h0, 4'b0100, 1'b0, 1, 1, 1'b0);
    m_acc = '0; m_a = 32'd9; m_b = 32'd9; m_ctrl = 4'hC;
`endif

    // Randomized commands against the model.
    for (int n = 0; n < 60; n++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
      a  = $urandom;
      b  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
      issue(op, a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Initiator side of the 32-bit ALU operand/opcode interface.
- Accepts one command at a time via valid/ready, drives registered operands and opcode to an external ALU instance, and holds them stable for a per-opcode settle time.
- Captures the ALU result and N/Z/C/V flags, and returns them on a valid/ready response channel.
- Provides an accumulator so chained operations can reuse the previous result as operand A.

Parameters:
- MULDIV_WAIT, 2, extra EXEC cycles for multicycle ops: mul 0100, div 0101, rem 1010.
- BASIC_WAIT, 0, extra EXEC cycles for all other opcodes.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  4  ALU opcode.
- cmd_a  in  32  operand A.
- cmd_b  in  32  operand B.
- cmd_use_acc  in  1  1: operand A = accumulator; cmd_a ignored.
- alu_a  out  32  registered operand A to ALU.
- alu_b  out  32  registered operand B to ALU.
- alu_ctrl  out  4  registered opcode to ALU.
- alu_result  in  32  ALU result.
- alu_overflow  in  1  ALU overflow flag.
- alu_carry  in  1  ALU carry flag.
- alu_zero  in  1  ALU zero flag.
- alu_negative  in  1  ALU negative flag.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes response.
- rsp_result  out  32  captured result.
- rsp_flags  out  4  {N,Z,C,V} captured.
- rsp_err  out  1  illegal-opcode response.
- busy  out  1  high in EXEC or RESP.

Behaviour:
- Reset is asynchronous, active-low. On reset:
  - State = IDLE.
  - alu_a, alu_b, rsp_result, and the accumulator = 0.
  - alu_ctrl = 0000; rsp_flags = 0.
  - rsp_valid, rsp_err, busy = 0.
  - cmd_ready = 1 once rst_n deasserts.
- A reset asserted mid-operation discards the in-flight command and any pending response. No response is produced for it.
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid at an edge:
    - alu_a <= (cmd_use_acc ? acc : cmd_a); alu_b <= cmd_b; alu_ctrl <= cmd_op.
    - cnt <= MULDIV_WAIT for 0100/0101/1010, else BASIC_WAIT.
    - Go to EXEC.
  - EXEC: cmd_ready=0. alu_* held constant.
    - If cnt != 0: cnt decrements.
    - If cnt == 0 at an edge: rsp_result <= alu_result; rsp_flags <= {alu_negative, alu_zero, alu_carry, alu_overflow}; acc <= alu_result; rsp_err <= 0. Go to RESP.
  - RESP: rsp_valid=1; response outputs stable.
    - On rsp_ready: go to IDLE; rsp_valid drops at that edge.
    - rsp_valid is never withdrawn without rsp_ready.
- alu_a/alu_b/alu_ctrl change only on command accept and otherwise hold their last values, so ALU inputs do not toggle in IDLE.
- Latency: accept edge E0 → capture edge E(1+wait) → rsp_valid high from E(1+wait).
  - Basic ops: rsp_valid high one edge after accept.
  - MULDIV_WAIT=2: three edges after accept.
- Throughput: one outstanding command. The next command is accepted no earlier than the edge after the response handshake; IDLE is entered for at least one cycle.
- cmd_ready is combinational from state only (state==IDLE), with no dependency on cmd_valid.
- Flags are passed through unmodified. C/V are meaningful only for 0000/0001; the sequencer does not mask them.
- Accumulator is 32-bit, updated only at capture, and persists across responses.
- Opcodes 1011–1111 without the feature: issued normally; the ALU yields 0; flags are captured as given.

Optional Feature:
- Macro: ALU_SEQ_ILLEGAL_OP_EN
- Defined:
  - An opcode 1011–1111 accepted in IDLE goes directly to RESP on the accept edge.
  - rsp_err=1, rsp_result=0, rsp_flags=0.
  - alu_* and the accumulator are unchanged; the ALU is not driven.
- Undefined: rsp_err is tied 0 and illegal opcodes are treated as normal commands.

Decomposition:
- Package alu_seq_pkg:
  - Opcode constants OP_ADD=0000, OP_SUB=0001, OP_AND=0010, OP_OR=0011, OP_MUL=0100, OP_DIV=0101, OP_SHR=0110, OP_SHL=0111, OP_CMP=1000, OP_SLT=1001, OP_REM=1010.
  - State encoding IDLE/EXEC/RESP.
  - Flag indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - Function is_multicycle(op).
- No sub-module. The ALU is instantiated alongside by the integrating level, not inside this block.

Test Plan:
- ADD a=0xFFFFFFFF b=1, rsp_ready=1 → rsp_valid one edge after accept; result 0x00000000, flags N0 Z1 C1 V0.
- SUB a=0x80000000 b=1 → result 0x7FFFFFFF, V=1, C=1; then cmd_use_acc=1, ADD b=1 → alu_a=0x7FFFFFFF, result 0x80000000, N=1, V=1.
- DIV a=100 b=7, MULDIV_WAIT=2 → alu_* stable for 3 cycles, rsp_valid three edges after accept, result 14; a following REM with the same operands gives result 2.
- rsp_ready held 0 for 5 cycles after a response → rsp_valid and rsp_result stay constant, cmd_ready=0, a second cmd_valid is not accepted; rsp_ready=1 → IDLE next edge.
- rst_n pulsed low during EXEC of a MUL → all outputs 0 immediately, no response after release, accumulator 0.
- With ALU_SEQ_ILLEGAL_OP_EN, op=1100 → rsp_valid on the accept edge, rsp_err=1, result 0, alu_ctrl retains its previous opcode. Without the macro → rsp_err=0, result 0, Z=1.
